// File: rtl/dp_issue.sv
// dp_issue: sequential issue/writeback controller for ARM data-processing
// instructions. Owns the NZCV flag register, evaluates the condition field,
// fetches Rn/Rm through one synchronous register-file read port, forms the
// shifter operand/carry, drives an external ALU and writes back Rd and flags.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   inst_valid, inst, inst_ready    instruction offer / accept (ready in IDLE)
//   rf_raddr, rf_rdata              read port, data returns one cycle later
//   alu_opcode, alu_a, alu_b        ALU operands (held outside EXEC)
//   alu_n/z/c/v, alu_shc            current flags, shifter carry out
//   alu_out, alu_c_in, alu_v_in     ALU result, carry, overflow
//   alu_wrd                         ALU result targets Rd
//   rf_we, rf_waddr, rf_wdata       register write-back (one-cycle pulse)
//   n, z, c, v                      flag register
//   done, skipped, undef            retire pulse and its qualifiers
//
// state  | meaning
// IDLE   | waiting for an instruction, inst_ready high
// COND   | condition / encoding check, Rn address presented
// RD_RN  | Rn data arrives; Rm address presented for register form
// RD_RM  | Rm data arrives and is shifted into the B operand
// EXEC   | ALU operands stable, ALU results captured
// WB     | Rd write pulse and done; flags update on the exit edge
module dp_issue #(
    parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_valid,
    input  logic [31:0] inst,
    output logic        inst_ready,
    output logic [3:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    output logic [3:0]  alu_opcode,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        alu_n,
    output logic        alu_z,
    output logic        alu_c,
    output logic        alu_v,
    output logic        alu_shc,
    input  logic [31:0] alu_out,
    input  logic        alu_c_in,
    input  logic        alu_v_in,
    input  logic        alu_wrd,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        n,
    output logic        z,
    output logic        c,
    output logic        v,
    output logic        done,
    output logic        skipped,
    output logic        undef
);

    typedef enum logic [2:0] {
        S_IDLE, S_COND, S_RD_RN, S_RD_RM, S_EXEC, S_WB
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_inst, r_alu_a, r_alu_b, r_res;
    logic        r_alu_shc, r_c_in, r_v_in, r_rf_we;
    logic        r_done, r_skipped, r_undef;
    logic [3:0]  r_flags;

    logic        w_fn, w_fz, w_fc, w_fv;
    logic        w_cond_pass, w_undef;
    logic [4:0]  w_amt, w_rot;
    logic [31:0] w_imm, w_sh_b;
    logic        w_sh_c;

    assign {w_fn, w_fz, w_fc, w_fv} = r_flags;
    assign w_amt = r_inst[11:7];
    assign w_rot = {r_inst[11:8], 1'b0};
    assign w_imm = {24'd0, r_inst[7:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        inst_ready  = 1'b0;
        rf_raddr    = r_inst[19:16];
        case (r_state)
            S_IDLE: begin
                inst_ready = 1'b1;
                if (inst_valid) w_state_nxt = S_COND;
            end
            S_COND:  w_state_nxt = (w_undef || !w_cond_pass) ? S_IDLE : S_RD_RN;
            S_RD_RN: begin
                rf_raddr    = r_inst[3:0];
                w_state_nxt = r_inst[25] ? S_EXEC : S_RD_RM;
            end
            S_RD_RM: w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = S_WB;
            S_WB:    w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_cond_pass = 1'b1;
        case (r_inst[31:28])
            4'h0: w_cond_pass = w_fz;
            4'h1: w_cond_pass = !w_fz;
            4'h2: w_cond_pass = w_fc;
            4'h3: w_cond_pass = !w_fc;
            4'h4: w_cond_pass = w_fn;
            4'h5: w_cond_pass = !w_fn;
            4'h6: w_cond_pass = w_fv;
            4'h7: w_cond_pass = !w_fv;
            4'h8: w_cond_pass = w_fc && !w_fz;
            4'h9: w_cond_pass = !w_fc || w_fz;
            4'hA: w_cond_pass = (w_fn == w_fv);
            4'hB: w_cond_pass = (w_fn != w_fv);
            4'hC: w_cond_pass = !w_fz && (w_fn == w_fv);
            4'hD: w_cond_pass = w_fz || (w_fn != w_fv);
            default: w_cond_pass = 1'b1;
        endcase
        // test/compare opcodes (10xx) without S would be other instruction classes
        w_undef = (r_inst[31:28] == 4'hF) || (r_inst[27:26] != 2'b00) ||
                  (!r_inst[25] && r_inst[4]) ||
                  ((r_inst[24:23] == 2'b10) && !r_inst[20]);
    end

    // Shifter works on rf_rdata directly: it is Rm while in RD_RM, and the
    // immediate form ignores it.
    always_comb begin
        w_sh_b = rf_rdata;
        w_sh_c = w_fc;
        if (r_inst[25]) begin
            w_sh_b = w_imm;
            if (w_rot != 5'd0) begin
                w_sh_b = (w_imm >> w_rot) | (w_imm << (6'd32 - {1'b0, w_rot}));
                w_sh_c = w_sh_b[31];
            end
        end else begin
            case (r_inst[6:5])
                2'b00: begin
                    if (w_amt != 5'd0) begin
                        w_sh_b = rf_rdata << w_amt;
                        // 5-bit wrap of 0-amt selects bit 32-amt
                        w_sh_c = rf_rdata[5'd0 - w_amt];
                    end
                end
                2'b01: begin
                    if (w_amt == 5'd0) begin
                        w_sh_b = 32'd0;
                        w_sh_c = rf_rdata[31];
                    end else begin
                        w_sh_b = rf_rdata >> w_amt;
                        w_sh_c = rf_rdata[w_amt - 5'd1];
                    end
                end
                2'b10: begin
                    if (w_amt == 5'd0) begin
                        w_sh_b = {32{rf_rdata[31]}};
                        w_sh_c = rf_rdata[31];
                    end else begin
                        w_sh_b = $signed(rf_rdata) >>> w_amt;
                        w_sh_c = rf_rdata[w_amt - 5'd1];
                    end
                end
                default: begin
                    if (w_amt == 5'd0) begin
                        w_sh_b = {w_fc, rf_rdata[31:1]};
                        w_sh_c = rf_rdata[0];
                    end else begin
                        w_sh_b = (rf_rdata >> w_amt) | (rf_rdata << (6'd32 - {1'b0, w_amt}));
                        w_sh_c = rf_rdata[w_amt - 5'd1];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inst    <= 32'd0;
            r_alu_a   <= 32'd0;
            r_alu_b   <= 32'd0;
            r_alu_shc <= 1'b0;
            r_res     <= 32'd0;
            r_c_in    <= 1'b0;
            r_v_in    <= 1'b0;
            r_rf_we   <= 1'b0;
            r_done    <= 1'b0;
            r_skipped <= 1'b0;
            r_undef   <= 1'b0;
            r_flags   <= FLAGS_RESET;
        end else begin
            r_rf_we   <= 1'b0;
            r_done    <= 1'b0;
            r_skipped <= 1'b0;
            r_undef   <= 1'b0;
            case (r_state)
                S_IDLE: if (inst_valid) r_inst <= inst;
                S_COND: begin
                    if (w_undef) begin
                        r_done  <= 1'b1;
                        r_undef <= 1'b1;
                    end else if (!w_cond_pass) begin
                        r_done    <= 1'b1;
                        r_skipped <= 1'b1;
                    end
                end
                S_RD_RN: begin
                    r_alu_a <= rf_rdata;
                    if (r_inst[25]) begin
                        r_alu_b   <= w_sh_b;
                        r_alu_shc <= w_sh_c;
                    end
                end
                S_RD_RM: begin
                    r_alu_b   <= w_sh_b;
                    r_alu_shc <= w_sh_c;
                end
                S_EXEC: begin
                    r_res   <= alu_out;
                    r_c_in  <= alu_c_in;
                    r_v_in  <= alu_v_in;
                    r_rf_we <= alu_wrd;
                    r_done  <= 1'b1;
                end
                S_WB: begin
                    if (r_inst[20])
                        r_flags <= {r_res[31], (r_res == 32'd0), r_c_in, r_v_in};
                end
                default: ;
            endcase
        end
    end

    assign alu_opcode = r_inst[24:21];
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_shc    = r_alu_shc;
    assign {alu_n, alu_z, alu_c, alu_v} = r_flags;
    assign {n, z, c, v} = r_flags;
    assign rf_we      = r_rf_we;
    assign rf_waddr   = r_inst[15:12];
    assign rf_wdata   = r_res;
    assign done       = r_done;
    assign skipped    = r_skipped;
    assign undef      = r_undef;

endmodule

// File: doc/dp_issue.md
Name: dp_issue

Overview:
Sequential issue/writeback controller for ARM data-processing instructions. It sits on the driving side of the ALU. It accepts a 32-bit instruction word and evaluates the condition field against the flag register it owns. It fetches Rn/Rm through a single synchronous register-file read port, forms the shifter operand and shifter carry, and drives the ALU. It then captures the ALU result and writes back Rd and the NZCV flags.

Parameters:
FLAGS_RESET, 4'b0000, reset value of {n,z,c,v}

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
inst_valid  in  1  instruction offered
inst  in  32  instruction word
inst_ready  out  1  high only in IDLE
rf_raddr  out  4  register read address; data returns next cycle
rf_rdata  in  32  register read data
alu_opcode  out  4  inst[24:21]
alu_a  out  32  latched Rn value
alu_b  out  32  shifter operand
alu_n, alu_z, alu_c, alu_v  out  1 each  current flag register
alu_shc  out  1  shifter carry out
alu_out  in  32  ALU result
alu_c_in, alu_v_in  in  1 each  ALU carry/overflow results
alu_wrd  in  1  ALU says result is written to Rd
rf_we  out  1  write enable, one-cycle pulse
rf_waddr  out  4  inst[15:12]
rf_wdata  out  32  registered ALU result
n, z, c, v  out  1 each  flag register
done  out  1  one-cycle pulse when instruction retires
skipped  out  1  valid with done; condition failed
undef  out  1  valid with done; unsupported encoding

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; {n,z,c,v}=FLAGS_RESET.
  - rf_we, done, skipped, undef = 0; all data outputs 0.
  - Reset mid-instruction abandons it with no register or flag write.
- IDLE: inst_ready=1. On inst_valid&inst_ready, latch inst and go to COND. inst_valid while busy is ignored (ready=0).
- COND: evaluate cond=inst[31:28] using the standard ARM table for 0000..1110 (1110 always).
  - undef if any of: cond=1111; inst[27:26]!=00; inst[25]=0 with inst[4]=1 (register-specified shift/multiply); opcode 10xx with S=0. Result: done=1, undef=1 next cycle, go to IDLE.
  - Condition false: done=1, skipped=1 next cycle, go to IDLE.
  - Otherwise rf_raddr=Rn (inst[19:16]), go to RD_RN.
- RD_RN: latch rf_rdata into a. If inst[25]=0, rf_raddr=Rm (inst[3:0]) and go to RD_RM; else go to EXEC.
- RD_RM: latch rf_rdata into m; go to EXEC.
- EXEC: alu_* outputs hold stable; register alu_out, alu_c_in, alu_v_in, alu_wrd, and alu_shc. Go to WB.
- WB:
  - rf_we = registered alu_wrd.
  - If S (inst[20]): n=res[31]; z=(res==0); c=alu_c_in; v=alu_v_in.
  - Flags take effect the cycle after WB.
  - done=1; go to IDLE.
- Latency from accept edge to done: immediate form 4 cycles, register form 5 cycles. Throughput is one instruction per latency+1 cycles.
- Immediate operand (inst[25]=1): b = imm8 ROR (2*rot4). shc = c if rot4=0, else b[31].
- Register operand with immediate shift, amt=inst[11:7], type=inst[6:5]:
  - LSL 0: b=m, shc=c.
  - LSL n: b=m<<n, shc=m[32-n].
  - LSR 0 means 32: b=0, shc=m[31]. LSR n: shc=m[n-1].
  - ASR 0 means 32: b={32{m[31]}}, shc=m[31]. ASR n: shc=m[n-1].
  - ROR 0 = RRX: b={c,m[31:1]}, shc=m[0]. ROR n: shc=m[n-1].
- R15 receives no special handling: reads and writes go straight to the register file.
- alu_opcode/alu_a/alu_b are don't-care outside EXEC; they are held at their last values.

Test Plan:
- Flags=0, inst 0xE3A01005 (MOV r1,#5) -> rf_we at cycle 4, waddr=1, wdata=5, flags unchanged, done=1, skipped=0.
- r2=0xFFFFFFFF, r3=1, inst 0xE0921003 (ADDS r1,r2,r3) -> wdata=0, z=1, c=1, n=0, v=0; done at cycle 5.
- z=0, inst 0x03A01007 (MOVEQ) -> done+skipped at cycle 2, no rf_we, flags unchanged.
- r4=0x80000001, inst 0xE1B05064 (MOVS r5,r4,RRX) with c=1 -> wdata=0xC0000000, c=1, n=1.
- r0=3, inst 0xE3500003 (CMP r0,#3) -> rf_we=0, z=1, c=1; then 0xE1A00110 (register-specified shift) -> undef=1, no writes.
- rst_n pulsed low during RD_RM -> immediate IDLE, flags=FLAGS_RESET, no rf_we; the next accepted instruction executes normally.
